eth_port_mgr: RTL and testbench
===============================

Name: eth_port_mgr

Overview:
Parametrised per-port Ethernet housekeeping block for NUM_PORTS 10G MAC ports, all in the clk156 domain. For each port it does four things: sequences a cold reset, debounces link status, re-resets the port on link loss, and keeps saturating frame statistics. It sits beside eth_encap and the MAC instances. port_rst drives the MAC and encap datapath resets. Counters are read through a registered port-select readout, and a summary byte drives the board debug LEDs.

Parameters:
NUM_PORTS, 2, number of Ethernet ports (1..8)
PSEL_WIDTH, 3, width of rd_port
CNT_WIDTH, 32, width of each statistics counter
COLD_CYCLES, 16383, clk156 cycles port_rst is held after reset or re-reset (>=1)
DEBOUNCE_CYCLES, 1023, consecutive cycles link_up_raw must be high before link_up asserts (>=1)
RERST_ON_LOS, 1, 1 = link_up falling edge in RUN restarts the cold reset; 0 = ignored

Ports:
clk156  in  1  single clock for the block
eth_rst_n  in  1  synchronous active-low reset
link_up_raw  in  NUM_PORTS  per-port raw link indication (!RX_LOS)
rx_tvalid  in  NUM_PORTS  MAC rx AXIS tvalid per port
rx_tlast  in  NUM_PORTS  MAC rx AXIS tlast per port
rx_tuser  in  NUM_PORTS  MAC rx AXIS tuser per port (1 = good frame on tlast)
tx_tvalid  in  NUM_PORTS  MAC tx AXIS tvalid per port
tx_tready  in  NUM_PORTS  MAC tx AXIS tready per port
tx_tlast  in  NUM_PORTS  MAC tx AXIS tlast per port
cnt_clr  in  1  single-cycle pulse, clears all counters of all ports
rd_port  in  PSEL_WIDTH  port index for counter readout
port_rst  out  NUM_PORTS  active-high per-port datapath reset
link_up  out  NUM_PORTS  debounced link status
rd_rx_good  out  CNT_WIDTH  good rx frame count of rd_port
rd_rx_bad  out  CNT_WIDTH  bad rx frame count of rd_port
rd_tx  out  CNT_WIDTH  tx frame count of rd_port
debug  out  8  LED summary

Behaviour:
- All state is updated on the rising edge of clk156.
- While eth_rst_n=0, every register is forced to its reset value:
  - port_rst = all 1s.
  - link_up = 0.
  - All counters = 0.
  - rd_* = 0.
  - debug = 0.
  - Every port FSM = COLD with its cold counter = 0.
- Per-port FSM, states COLD and RUN:
  - COLD: port_rst[i]=1 and the cold counter increments each cycle. When the counter reaches COLD_CYCLES-1, go to RUN on the next edge. port_rst[i] therefore stays 1 for exactly COLD_CYCLES cycles after reset deasserts.
  - RUN: port_rst[i]=0.
  - If RERST_ON_LOS=1 and link_up[i] falls (registered 1 to 0) while in RUN, go to COLD with the cold counter cleared. port_rst[i] is 1 on the next cycle.
  - A link_up fall while in COLD has no effect on the sequence.
- Debounce, per port:
  - The saturating counter increments while link_up_raw[i]=1 and clears to 0 the cycle link_up_raw[i]=0.
  - link_up[i] sets on the edge where the counter reaches DEBOUNCE_CYCLES-1 with raw still 1, i.e. DEBOUNCE_CYCLES cycles of raw high.
  - link_up[i] clears on the edge after raw goes low (1 cycle latency).
  - Debounce runs independently of the FSM state.
- Counters, per port, only incremented while the port is in RUN:
  - rx_good increments on rx_tvalid & rx_tlast & rx_tuser.
  - rx_bad increments on rx_tvalid & rx_tlast & ~rx_tuser.
  - tx increments on tx_tvalid & tx_tready & tx_tlast.
  - tx with tready=0 does not count.
  - Counters saturate at all 1s and do not wrap.
  - cnt_clr has priority: an increment coincident with cnt_clr is dropped and the counter reads 0.
  - Re-entering COLD does not clear counters.
- Readout:
  - rd_* are registered from rd_port with 1-cycle latency.
  - rd_port >= NUM_PORTS returns 0 on all three outputs.
  - The readout reflects counter values as of the previous edge.
- debug, registered:
  - debug[i] = link_up[i] for i < min(NUM_PORTS,4).
  - debug[4+i] = ~port_rst[i] for i < min(NUM_PORTS,4).
  - Unused bits are 0.
- No backpressure is produced; all AXIS inputs are observe-only.

Test Plan:
- Reset release (COLD_CYCLES=10, NUM_PORTS=2) -> port_rst=2'b11 for exactly 10 cycles after eth_rst_n rises, then 2'b00. debug[5:4] goes 2'b11 one cycle later.
- Debounce (DEBOUNCE_CYCLES=4): raw high 3 cycles, low 1, high 4 -> link_up stays 0 through the first burst and asserts on the 4th cycle of the second burst. Raw drop -> link_up=0 one cycle later.
- Link loss re-reset (RERST_ON_LOS=1): port 1 in RUN, link_up[1] falls -> port_rst[1]=1 for 10 cycles, then 0. Port 0 is unaffected and its counters are retained. The same case with RERST_ON_LOS=0 -> port_rst[1] stays 0.
- Counting on port 0: 3 frames with tuser=1, 2 with tuser=0, and 4 tx frames, one of which has tready=0 on tlast for a cycle before acceptance. rd_port=0 -> rd_rx_good=3, rd_rx_bad=2, rd_tx=4 one cycle after select. rd_port=5 -> all 0.
- Saturation and clear (CNT_WIDTH=4): 17 good frames -> rd_rx_good=15. Then cnt_clr coincident with a good tlast -> rd_rx_good=0.
- Counting gated in COLD: frames on port 1 during its cold period -> all port 1 counters remain 0.

Source files
------------

// File: rtl/eth_port_mgr_if.sv
// ----------------------------------------------------------------------------
// eth_port_mgr_if : status, AXIS observe and counter readout bundle for eth_port_mgr
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface eth_port_mgr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int PSEL_WIDTH = 3,
  parameter int CNT_WIDTH  = 32
);
  logic [NUM_PORTS-1:0]  link_up_raw;
  logic [NUM_PORTS-1:0]  rx_tvalid;
  logic [NUM_PORTS-1:0]  rx_tlast;
  logic [NUM_PORTS-1:0]  rx_tuser;
  logic [NUM_PORTS-1:0]  tx_tvalid;
  logic [NUM_PORTS-1:0]  tx_tready;
  logic [NUM_PORTS-1:0]  tx_tlast;
  logic                  cnt_clr;
  logic [PSEL_WIDTH-1:0] rd_port;
  logic [NUM_PORTS-1:0]  port_rst;
  logic [NUM_PORTS-1:0]  link_up;
  logic [CNT_WIDTH-1:0]  rd_rx_good;
  logic [CNT_WIDTH-1:0]  rd_rx_bad;
  logic [CNT_WIDTH-1:0]  rd_tx;
  logic [7:0]            debug;

  modport slave (
    input  link_up_raw, rx_tvalid, rx_tlast, rx_tuser, tx_tvalid, tx_tready, tx_tlast,
    input  cnt_clr, rd_port,
    output port_rst, link_up, rd_rx_good, rd_rx_bad, rd_tx, debug
  );

  modport master (
    output link_up_raw, rx_tvalid, rx_tlast, rx_tuser, tx_tvalid, tx_tready, tx_tlast,
    output cnt_clr, rd_port,
    input  port_rst, link_up, rd_rx_good, rd_rx_bad, rd_tx, debug
  );
endinterface

`default_nettype wire

// File: rtl/eth_port_mgr.sv
// ----------------------------------------------------------------------------
// eth_port_mgr : per-port cold reset sequencing, link debounce, re-reset on
//                link loss, saturating frame statistics and debug LED summary
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_port_mgr #(
  parameter int NUM_PORTS       = 2,
  parameter int PSEL_WIDTH      = 3,
  parameter int CNT_WIDTH       = 32,
  parameter int COLD_CYCLES     = 16383,
  parameter int DEBOUNCE_CYCLES = 1023,
  parameter int RERST_ON_LOS    = 1
) (
  input  logic          clk156,
  input  logic          eth_rst_n,
  eth_port_mgr_if.slave bus
);

  localparam int COLD_W = $clog2(COLD_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DBG_N  = (NUM_PORTS < 4) ? NUM_PORTS : 4;

  localparam logic [COLD_W-1:0] COLD_LAST = COLD_W'(COLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_COLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NUM_PORTS-1:0]                 state_q, state_d;
  logic [NUM_PORTS-1:0][COLD_W-1:0]     cold_cnt_q, cold_cnt_d;
  logic [NUM_PORTS-1:0][DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
  logic [NUM_PORTS-1:0]                 link_up_q, link_up_d;
  logic [NUM_PORTS-1:0]                 link_prev_q, link_prev_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  rx_good_q, rx_good_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  rx_bad_q, rx_bad_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  tx_q, tx_d;
  logic [CNT_WIDTH-1:0]                 rd_rx_good_q, rd_rx_good_d;
  logic [CNT_WIDTH-1:0]                 rd_rx_bad_q, rd_rx_bad_d;
  logic [CNT_WIDTH-1:0]                 rd_tx_q, rd_tx_d;
  logic [7:0]                           debug_q, debug_d;
  logic [NUM_PORTS-1:0]                 port_rst;

  // Clear wins over increment; increments stop at all ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 clr,
    input logic                 inc
  );
    if (clr)
      return '0;
    else if (inc && !(&cnt))
      return cnt + CNT_WIDTH'(1);
    else
      return cnt;
  endfunction

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state_q      <= {NUM_PORTS{ST_COLD}};
      cold_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      link_up_q    <= '0;
      link_prev_q  <= '0;
      rx_good_q    <= '0;
      rx_bad_q     <= '0;
      tx_q         <= '0;
      rd_rx_good_q <= '0;
      rd_rx_bad_q  <= '0;
      rd_tx_q      <= '0;
      debug_q      <= '0;
    end else begin
      state_q      <= state_d;
      cold_cnt_q   <= cold_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      link_up_q    <= link_up_d;
      link_prev_q  <= link_prev_d;
      rx_good_q    <= rx_good_d;
      rx_bad_q     <= rx_bad_d;
      tx_q         <= tx_d;
      rd_rx_good_q <= rd_rx_good_d;
      rd_rx_bad_q  <= rd_rx_bad_d;
      rd_tx_q      <= rd_tx_d;
      debug_q      <= debug_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cold_cnt_d  = cold_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    link_up_d   = link_up_q;
    link_prev_d = link_up_q;
    rx_good_d   = rx_good_q;
    rx_bad_d    = rx_bad_q;
    tx_d        = tx_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      // Debounce counter parks at its last value while raw stays high.
      if (!bus.link_up_raw[p]) begin
        deb_cnt_d[p] = '0;
        link_up_d[p] = 1'b0;
      end else if (deb_cnt_q[p] == DEB_LAST) begin
        link_up_d[p] = 1'b1;
      end else begin
        deb_cnt_d[p] = deb_cnt_q[p] + DEB_W'(1);
      end

      case (state_q[p])
        ST_COLD: begin
          if (cold_cnt_q[p] == COLD_LAST)
            state_d[p] = ST_RUN;
          else
            cold_cnt_d[p] = cold_cnt_q[p] + COLD_W'(1);
        end
        default: begin
          if ((RERST_ON_LOS != 0) && link_prev_q[p] && !link_up_q[p]) begin
            state_d[p]    = ST_COLD;
            cold_cnt_d[p] = '0;
          end
        end
      endcase

      rx_good_d[p] = sat_inc(rx_good_q[p], bus.cnt_clr, (state_q[p] == ST_RUN) &&
                             bus.rx_tvalid[p] && bus.rx_tlast[p] && bus.rx_tuser[p]);
      rx_bad_d[p]  = sat_inc(rx_bad_q[p], bus.cnt_clr, (state_q[p] == ST_RUN) &&
                             bus.rx_tvalid[p] && bus.rx_tlast[p] && !bus.rx_tuser[p]);
      tx_d[p]      = sat_inc(tx_q[p], bus.cnt_clr, (state_q[p] == ST_RUN) &&
                             bus.tx_tvalid[p] && bus.tx_tready[p] && bus.tx_tlast[p]);
    end
  end

  always_comb begin
    rd_rx_good_d = '0;
    rd_rx_bad_d  = '0;
    rd_tx_d      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.rd_port == PSEL_WIDTH'(p)) begin
        rd_rx_good_d = rx_good_q[p];
        rd_rx_bad_d  = rx_bad_q[p];
        rd_tx_d      = tx_q[p];
      end
    end
    debug_d = '0;
    for (int p = 0; p < DBG_N; p++) begin
      debug_d[p]     = link_up_q[p];
      debug_d[4 + p] = ~port_rst[p];
    end
  end

  always_comb begin
    port_rst = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      port_rst[p] = (state_q[p] == ST_COLD);
  end

  assign bus.port_rst   = port_rst;
  assign bus.link_up    = link_up_q;
  assign bus.rd_rx_good = rd_rx_good_q;
  assign bus.rd_rx_bad  = rd_rx_bad_q;
  assign bus.rd_tx      = rd_tx_q;
  assign bus.debug      = debug_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_port_mgr.sv
// ----------------------------------------------------------------------------
// tb_eth_port_mgr : directed bench; dut_a re-resets on link loss, dut_b does not
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_eth_port_mgr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  eth_port_mgr_if #(.NUM_PORTS(2), .PSEL_WIDTH(3), .CNT_WIDTH(4)) if_a ();
  eth_port_mgr_if #(.NUM_PORTS(2), .PSEL_WIDTH(3), .CNT_WIDTH(4)) if_b ();

  assign if_b.link_up_raw = if_a.link_up_raw;
  assign if_b.rx_tvalid   = if_a.rx_tvalid;
  assign if_b.rx_tlast    = if_a.rx_tlast;
  assign if_b.rx_tuser    = if_a.rx_tuser;
  assign if_b.tx_tvalid   = if_a.tx_tvalid;
  assign if_b.tx_tready   = if_a.tx_tready;
  assign if_b.tx_tlast    = if_a.tx_tlast;
  assign if_b.cnt_clr     = if_a.cnt_clr;
  assign if_b.rd_port     = if_a.rd_port;

  eth_port_mgr #(.NUM_PORTS(2), .PSEL_WIDTH(3), .CNT_WIDTH(4), .COLD_CYCLES(10),
                 .DEBOUNCE_CYCLES(4), .RERST_ON_LOS(1)) dut_a (
    .clk156(clk), .eth_rst_n(rst_n), .bus(if_a));

  eth_port_mgr #(.NUM_PORTS(2), .PSEL_WIDTH(3), .CNT_WIDTH(4), .COLD_CYCLES(10),
                 .DEBOUNCE_CYCLES(4), .RERST_ON_LOS(0)) dut_b (
    .clk156(clk), .eth_rst_n(rst_n), .bus(if_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input int p, input logic good);
    if_a.rx_tvalid[p] = 1'b1; if_a.rx_tlast[p] = 1'b0; if_a.rx_tuser[p] = 1'b0;
    tick;
    if_a.rx_tlast[p] = 1'b1; if_a.rx_tuser[p] = good;
    tick;
    if_a.rx_tvalid[p] = 1'b0; if_a.rx_tlast[p] = 1'b0; if_a.rx_tuser[p] = 1'b0;
  endtask

  task automatic tx_frame(input int p, input logic stall);
    if_a.tx_tvalid[p] = 1'b1; if_a.tx_tready[p] = 1'b1; if_a.tx_tlast[p] = 1'b0;
    tick;
    if_a.tx_tlast[p] = 1'b1;
    if (stall) begin
      if_a.tx_tready[p] = 1'b0;
      tick;
      if_a.tx_tready[p] = 1'b1;
    end
    tick;
    if_a.tx_tvalid[p] = 1'b0; if_a.tx_tready[p] = 1'b0; if_a.tx_tlast[p] = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    if_a.link_up_raw = '0; if_a.rx_tvalid = '0; if_a.rx_tlast = '0; if_a.rx_tuser = '0;
    if_a.tx_tvalid = '0; if_a.tx_tready = '0; if_a.tx_tlast = '0;
    if_a.cnt_clr = 1'b0; if_a.rd_port = '0;
    repeat (3) tick;
    checks++; if (if_a.port_rst !== 2'b11) begin errors++; $display("FAIL reset_port_rst got %b exp 11", if_a.port_rst); end
    checks++; if (if_a.link_up !== 2'b00) begin errors++; $display("FAIL reset_link_up got %b exp 00", if_a.link_up); end
    checks++; if (if_a.debug !== 8'h00) begin errors++; $display("FAIL reset_debug got %h exp 00", if_a.debug); end
    checks++; if ({if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx} !== 12'h000) begin
      errors++; $display("FAIL reset_rd got %h exp 000", {if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx}); end
    rst_n = 1'b1;
    n = 0;
    do begin tick; n++; end while (if_a.port_rst == 2'b11 && n < 50);
    checks++; if (n !== 10) begin errors++; $display("FAIL cold_len got %0d exp 10", n); end
    checks++; if (if_a.port_rst !== 2'b00) begin errors++; $display("FAIL cold_end got %b exp 00", if_a.port_rst); end
    checks++; if (if_a.debug[5:4] !== 2'b00) begin errors++; $display("FAIL debug_lag got %b exp 00", if_a.debug[5:4]); end
    tick;
    checks++; if (if_a.debug[5:4] !== 2'b11) begin errors++; $display("FAIL debug_run got %b exp 11", if_a.debug[5:4]); end
  endtask

  task automatic test_debounce;
    int n;
    if_a.link_up_raw[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (if_a.link_up[0] !== 1'b0) begin errors++; $display("FAIL deb_burst1 cyc %0d got %b exp 0", i, if_a.link_up[0]); end
    end
    if_a.link_up_raw[0] = 1'b0;
    tick;
    if_a.link_up_raw[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (if_a.link_up[0] !== 1'b0) begin errors++; $display("FAIL deb_burst2 cyc %0d got %b exp 0", i, if_a.link_up[0]); end
    end
    tick;
    checks++; if (if_a.link_up[0] !== 1'b1) begin errors++; $display("FAIL deb_assert got %b exp 1", if_a.link_up[0]); end
    tick;
    checks++; if (if_a.debug[0] !== 1'b1) begin errors++; $display("FAIL deb_debug got %b exp 1", if_a.debug[0]); end
    if_a.link_up_raw[0] = 1'b0;
    tick;
    checks++; if (if_a.link_up[0] !== 1'b0) begin errors++; $display("FAIL deb_drop got %b exp 0", if_a.link_up[0]); end
    checks++; if (if_a.port_rst[0] !== 1'b0) begin errors++; $display("FAIL los_p0_early got %b exp 0", if_a.port_rst[0]); end
    tick;
    checks++; if (if_a.port_rst[0] !== 1'b1) begin errors++; $display("FAIL los_p0_rerst got %b exp 1", if_a.port_rst[0]); end
    n = 0;
    while (if_a.port_rst[0] == 1'b1 && n < 50) begin tick; n++; end
    checks++; if (n !== 10) begin errors++; $display("FAIL los_p0_len got %0d exp 10", n); end
  endtask

  task automatic test_counting;
    rx_frame(0, 1'b1); rx_frame(0, 1'b0); rx_frame(0, 1'b1);
    rx_frame(0, 1'b0); rx_frame(0, 1'b1);
    tx_frame(0, 1'b0); tx_frame(0, 1'b1); tx_frame(0, 1'b0); tx_frame(0, 1'b0);
    if_a.rd_port = 3'd0;
    tick;
    checks++; if (if_a.rd_rx_good !== 4'd3) begin errors++; $display("FAIL cnt_rx_good got %0d exp 3", if_a.rd_rx_good); end
    checks++; if (if_a.rd_rx_bad !== 4'd2) begin errors++; $display("FAIL cnt_rx_bad got %0d exp 2", if_a.rd_rx_bad); end
    checks++; if (if_a.rd_tx !== 4'd4) begin errors++; $display("FAIL cnt_tx got %0d exp 4", if_a.rd_tx); end
    if_a.rd_port = 3'd5;
    tick;
    checks++; if ({if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx} !== 12'h000) begin
      errors++; $display("FAIL rd_oob got %h exp 000", {if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx}); end
  endtask

  task automatic test_link_loss;
    int  n;
    logic b_rst_seen;
    if_a.link_up_raw[1] = 1'b1;
    repeat (4) tick;
    checks++; if (if_a.link_up[1] !== 1'b1) begin errors++; $display("FAIL p1_link got %b exp 1", if_a.link_up[1]); end
    if_a.link_up_raw[1] = 1'b0;
    tick;
    tick;
    checks++; if (if_a.port_rst !== 2'b10) begin errors++; $display("FAIL p1_rerst got %b exp 10", if_a.port_rst); end
    b_rst_seen = if_b.port_rst[1];
    // Frames offered to port 1 throughout its cold period.
    if_a.rx_tvalid[1] = 1'b1; if_a.rx_tlast[1] = 1'b1; if_a.rx_tuser[1] = 1'b1;
    if_a.tx_tvalid[1] = 1'b1; if_a.tx_tready[1] = 1'b1; if_a.tx_tlast[1] = 1'b1;
    n = 0;
    do begin
      tick; n++;
      b_rst_seen = b_rst_seen | if_b.port_rst[1];
    end while (if_a.port_rst[1] == 1'b1 && n < 50);
    if_a.rx_tvalid[1] = 1'b0; if_a.rx_tlast[1] = 1'b0; if_a.rx_tuser[1] = 1'b0;
    if_a.tx_tvalid[1] = 1'b0; if_a.tx_tready[1] = 1'b0; if_a.tx_tlast[1] = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL p1_cold_len got %0d exp 10", n); end
    checks++; if (b_rst_seen !== 1'b0) begin errors++; $display("FAIL norerst_p1 got %b exp 0", b_rst_seen); end
    if_a.rd_port = 3'd1;
    tick;
    checks++; if ({if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx} !== 12'h000) begin
      errors++; $display("FAIL p1_gated got %h exp 000", {if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx}); end
    checks++; if (if_b.rd_rx_good !== 4'd10) begin errors++; $display("FAIL norerst_p1_cnt got %0d exp 10", if_b.rd_rx_good); end
    if_a.rd_port = 3'd0;
    tick;
    checks++; if ({if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx} !== 12'h324) begin
      errors++; $display("FAIL p0_retained got %h exp 324", {if_a.rd_rx_good, if_a.rd_rx_bad, if_a.rd_tx}); end
  endtask

  task automatic test_saturation;
    if_a.rx_tvalid[0] = 1'b1; if_a.rx_tlast[0] = 1'b1; if_a.rx_tuser[0] = 1'b1;
    repeat (17) tick;
    if_a.rx_tvalid[0] = 1'b0; if_a.rx_tlast[0] = 1'b0; if_a.rx_tuser[0] = 1'b0;
    tick;
    checks++; if (if_a.rd_rx_good !== 4'd15) begin errors++; $display("FAIL sat_rx_good got %0d exp 15", if_a.rd_rx_good); end
    if_a.rx_tvalid[0] = 1'b1; if_a.rx_tlast[0] = 1'b1; if_a.rx_tuser[0] = 1'b1;
    if_a.cnt_clr = 1'b1;
    tick;
    if_a.rx_tvalid[0] = 1'b0; if_a.rx_tlast[0] = 1'b0; if_a.rx_tuser[0] = 1'b0;
    if_a.cnt_clr = 1'b0;
    tick;
    checks++; if (if_a.rd_rx_good !== 4'd0) begin errors++; $display("FAIL clr_rx_good got %0d exp 0", if_a.rd_rx_good); end
    checks++; if (if_a.rd_tx !== 4'd0) begin errors++; $display("FAIL clr_tx got %0d exp 0", if_a.rd_tx); end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_counting;
    test_link_loss;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
